ex_adder_arb: RTL

- Round-robin arbiter that shares one combinational 32-bit EX-stage adder (add_in1, add_in2 -> add_out) between NUM_REQ requesters, e.g. PC+4 and branch-target computation.
- Accepts at most one operand pair per cycle over a valid/ready handshake, drives the shared adder and registers the sum into a single-entry response buffer tagged with the requester ID.
- Sits in the EX stage between the operand sources and the shared adder instance.

---
 rtl/ex_adder_arb_pkg.sv | 26 ++
 rtl/ex_adder_arb_if.sv | 39 +++
 rtl/ex_adder_arb_rr_pick.sv | 32 +++
 rtl/ex_adder_arb.sv | 86 ++++++++
 4 files changed

// File: rtl/ex_adder_arb_pkg.sv
// rtl/ex_adder_arb_pkg.sv - shared constants, types and helpers for ex_adder_arb (EX_ADDER_ARB_OVF_EN adds rsp_t.ovf)
package ex_adder_arb_pkg;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_DATA_W  = 32;
  localparam int MAX_ID_W    = 3;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  function automatic int id_w(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  // Fields sized for the widest supported configuration; narrower builds use the low bits
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [MAX_ID_W-1:0]   id;
`ifdef EX_ADDER_ARB_OVF_EN
    logic                  ovf;
`endif
  } rsp_t;

endpackage

// File: rtl/ex_adder_arb_if.sv
// rtl/ex_adder_arb_if.sv - request, shared-adder and response signals of ex_adder_arb (EX_ADDER_ARB_OVF_EN adds rsp_ovf)
interface ex_adder_arb_if #(
  parameter int NUM_REQ = ex_adder_arb_pkg::DEF_NUM_REQ,
  parameter int DATA_W  = ex_adder_arb_pkg::DEF_DATA_W,
  parameter int ID_W    = ex_adder_arb_pkg::id_w(NUM_REQ)
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [DATA_W-1:0]         add_in1;
  logic [DATA_W-1:0]         add_in2;
  logic [DATA_W-1:0]         add_out;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic [ID_W-1:0]           rsp_id;
`ifdef EX_ADDER_ARB_OVF_EN
  logic                      rsp_ovf;
`endif

  modport master (
    output req_valid, req_a, req_b, add_out, rsp_ready,
`ifdef EX_ADDER_ARB_OVF_EN
    input  rsp_ovf,
`endif
    input  req_ready, add_in1, add_in2, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, add_out, rsp_ready,
`ifdef EX_ADDER_ARB_OVF_EN
    output rsp_ovf,
`endif
    output req_ready, add_in1, add_in2, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/ex_adder_arb_rr_pick.sv
// rtl/ex_adder_arb_rr_pick.sv - round-robin picker: first asserted request at or after ptr, wrapping
module ex_adder_arb_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  always_comb begin
    int   j;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      if (!found && req[ID_W'(j)]) begin
        found           = 1'b1;
        gnt[ID_W'(j)]   = 1'b1;
        idx             = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/ex_adder_arb.sv
// rtl/ex_adder_arb.sv - round-robin sharing of one EX-stage adder with a one-entry response buffer (EX_ADDER_ARB_OVF_EN adds rsp_ovf)
module ex_adder_arb
  import ex_adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input logic           clk,
  input logic           rst,
  ex_adder_arb_if.slave bus
);

  buf_state_t         state_q, state_d;
  rsp_t               rsp_q, rsp_d;
  logic [ID_W-1:0]    rr_ptr, ptr_d;
  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gidx;
  logic               grant;
  logic               can_accept;
  logic [DATA_W-1:0]  op_a, op_b;
  logic               unused_rsp_hi;

  assign can_accept = (state_q == BUF_EMPTY) || bus.rsp_ready;
  // A grant during reset would consume a request whose result is thrown away
  assign req_eff    = (can_accept && !rst) ? bus.req_valid : '0;

  ex_adder_arb_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_pick (
    .req(req_eff),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(gidx)
  );

  assign grant = |gnt;
  assign op_a  = bus.req_a[int'(gidx)*DATA_W +: DATA_W];
  assign op_b  = bus.req_b[int'(gidx)*DATA_W +: DATA_W];

  assign bus.req_ready = gnt;
  assign bus.add_in1   = grant ? op_a : '0;
  assign bus.add_in2   = grant ? op_b : '0;
  assign bus.rsp_valid = (state_q == BUF_FULL);
  assign bus.rsp_data  = rsp_q.data[DATA_W-1:0];
  assign bus.rsp_id    = rsp_q.id[ID_W-1:0];
`ifdef EX_ADDER_ARB_OVF_EN
  assign bus.rsp_ovf   = rsp_q.ovf;
`endif
  assign unused_rsp_hi = ^{rsp_q.data, rsp_q.id};

  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    ptr_d   = rr_ptr;
    if (grant) begin
      state_d                = BUF_FULL;
      rsp_d.data             = '0;
      rsp_d.data[DATA_W-1:0] = bus.add_out;
      rsp_d.id               = '0;
      rsp_d.id[ID_W-1:0]     = gidx;
`ifdef EX_ADDER_ARB_OVF_EN
      rsp_d.ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                  (bus.add_out[DATA_W-1] != op_a[DATA_W-1]);
`endif
      ptr_d = (gidx == ID_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
    end else if (bus.rsp_ready) begin
      state_d = BUF_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      rsp_q   <= '0;
      rr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      rr_ptr  <= ptr_d;
    end
  end

endmodule
